// File: rtl/ps2_command_tx_if.sv
// ps2_command_tx_if: bundles the command handshake and the PS/2 line signals
// of ps2_command_tx.
//   send_command / the_command        : command request and byte to send
//   busy                              : transfer in progress
//   command_was_sent / error_timeout /
//   error_no_ack                      : one-cycle completion/error pulses
//   ps2_clock_in / ps2_data_in        : raw PS/2 line levels (asynchronous)
//   ps2_clock_oe / ps2_data_oe        : 1 = pull the line low, 0 = release
// Modport slave is the transmitter side; master is the requester/line side.
interface ps2_command_tx_if;
  logic       send_command;
  logic [7:0] the_command;
  logic       ps2_clock_in;
  logic       ps2_data_in;
  logic       ps2_clock_oe;
  logic       ps2_data_oe;
  logic       busy;
  logic       command_was_sent;
  logic       error_timeout;
  logic       error_no_ack;

  modport slave (
    input  send_command, the_command, ps2_clock_in, ps2_data_in,
    output ps2_clock_oe, ps2_data_oe, busy, command_was_sent,
           error_timeout, error_no_ack
  );

  modport master (
    output send_command, the_command, ps2_clock_in, ps2_data_in,
    input  ps2_clock_oe, ps2_data_oe, busy, command_was_sent,
           error_timeout, error_no_ack
  );
endinterface

// File: rtl/ps2_command_tx.sv
// ps2_command_tx: host-to-device PS/2 command transmitter.
// Inhibits the bus by holding clock low, issues the start bit, then shifts
// the command byte, odd parity and stop bit out on device falling edges and
// checks the device ACK. All outputs are registered.
// Ports:
//   inclock : system clock, rising-edge active
//   resetn  : asynchronous active-low reset
//   bus     : ps2_command_tx_if.slave (handshake, pulses, PS/2 lines)
// Parameters:
//   INHIBIT_CYCLES       : cycles the clock line is held low before start
//   START_TIMEOUT_CYCLES : limit from clock release to first device edge
//   XFER_TIMEOUT_CYCLES  : limit from first device edge to bus idle after ACK
module ps2_command_tx #(
  parameter int unsigned INHIBIT_CYCLES       = 5000,
  parameter int unsigned START_TIMEOUT_CYCLES = 750000,
  parameter int unsigned XFER_TIMEOUT_CYCLES  = 100000
) (
  input  logic             inclock,
  input  logic             resetn,
  ps2_command_tx_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, INHIBIT, REQ_START, SEND, WAIT_IDLE} state_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  state_t      state_q, state_n;
  logic [31:0] cnt_q, cnt_n;
  logic [31:0] xfer_q, xfer_n;
  logic [3:0]  bit_q, bit_n;
  logic [9:0]  sr_q, sr_n;
  logic        clk_p0, clk_p1, clk_p2;
  logic        dat_p0, dat_p1;
  logic        clock_oe_q, clock_oe_n;
  logic        data_oe_q, data_oe_n;
  logic        busy_q, busy_n;
  logic        sent_q, sent_n;
  logic        to_q, to_n;
  logic        nack_q, nack_n;
  logic        fall;

  // p0 -> p1 synchronizes the lines; p2 holds the previous synchronized clock
  assign fall = clk_p2 & ~clk_p1;

  always_ff @(posedge inclock or negedge resetn) begin
    if (!resetn) begin
      clk_p0 <= 1'b1;
      clk_p1 <= 1'b1;
      clk_p2 <= 1'b1;
      dat_p0 <= 1'b1;
      dat_p1 <= 1'b1;
    end else begin
      clk_p0 <= bus.ps2_clock_in;
      clk_p1 <= clk_p0;
      clk_p2 <= clk_p1;
      dat_p0 <= bus.ps2_data_in;
      dat_p1 <= dat_p0;
    end
  end

  always_ff @(posedge inclock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      xfer_q     <= '0;
      bit_q      <= '0;
      sr_q       <= '0;
      clock_oe_q <= 1'b0;
      data_oe_q  <= 1'b0;
      busy_q     <= 1'b0;
      sent_q     <= 1'b0;
      to_q       <= 1'b0;
      nack_q     <= 1'b0;
    end else begin
      state_q    <= state_n;
      cnt_q      <= cnt_n;
      xfer_q     <= xfer_n;
      bit_q      <= bit_n;
      sr_q       <= sr_n;
      clock_oe_q <= clock_oe_n;
      data_oe_q  <= data_oe_n;
      busy_q     <= busy_n;
      sent_q     <= sent_n;
      to_q       <= to_n;
      nack_q     <= nack_n;
    end
  end

  always_comb begin
    state_n    = state_q;
    cnt_n      = cnt_q;
    xfer_n     = xfer_q;
    bit_n      = bit_q;
    sr_n       = sr_q;
    clock_oe_n = clock_oe_q;
    data_oe_n  = data_oe_q;
    busy_n     = busy_q;
    sent_n     = 1'b0;
    to_n       = 1'b0;
    nack_n     = 1'b0;
    case (state_q)
      IDLE: begin
        clock_oe_n = 1'b0;
        data_oe_n  = 1'b0;
        busy_n     = 1'b0;
        if (bus.send_command) begin
          // frame shifted out LSB first: d0..d7, odd parity, stop
          sr_n       = {1'b1, ~^bus.the_command, bus.the_command};
          cnt_n      = '0;
          xfer_n     = '0;
          bit_n      = '0;
          clock_oe_n = 1'b1;
          busy_n     = 1'b1;
          state_n    = INHIBIT;
        end
      end
      INHIBIT: begin
        cnt_n = sat_inc(cnt_q);
        if (cnt_q >= INHIBIT_CYCLES - 1) begin
          clock_oe_n = 1'b0;
          data_oe_n  = 1'b1;
          cnt_n      = '0;
          state_n    = REQ_START;
        end
      end
      REQ_START: begin
        cnt_n = sat_inc(cnt_q);
        if (fall) begin
          data_oe_n = ~sr_q[0];
          sr_n      = {1'b0, sr_q[9:1]};
          bit_n     = 4'd1;
          xfer_n    = '0;
          state_n   = SEND;
        end else if (cnt_q >= START_TIMEOUT_CYCLES - 1) begin
          to_n       = 1'b1;
          clock_oe_n = 1'b0;
          data_oe_n  = 1'b0;
          busy_n     = 1'b0;
          state_n    = IDLE;
        end
      end
      SEND: begin
        xfer_n = sat_inc(xfer_q);
        if (xfer_q >= XFER_TIMEOUT_CYCLES - 1) begin
          to_n       = 1'b1;
          clock_oe_n = 1'b0;
          data_oe_n  = 1'b0;
          busy_n     = 1'b0;
          state_n    = IDLE;
        end else if (fall) begin
          if (bit_q == 4'd10) begin
            // eleventh edge: device ACK must hold data low
            if (dat_p1) begin
              nack_n     = 1'b1;
              clock_oe_n = 1'b0;
              data_oe_n  = 1'b0;
              busy_n     = 1'b0;
              state_n    = IDLE;
            end else begin
              state_n = WAIT_IDLE;
            end
          end else begin
            data_oe_n = ~sr_q[0];
            sr_n      = {1'b0, sr_q[9:1]};
            bit_n     = bit_q + 4'd1;
          end
        end
      end
      WAIT_IDLE: begin
        xfer_n = sat_inc(xfer_q);
        if (xfer_q >= XFER_TIMEOUT_CYCLES - 1) begin
          to_n       = 1'b1;
          clock_oe_n = 1'b0;
          data_oe_n  = 1'b0;
          busy_n     = 1'b0;
          state_n    = IDLE;
        end else if (clk_p1 && dat_p1) begin
          sent_n  = 1'b1;
          busy_n  = 1'b0;
          state_n = IDLE;
        end
      end
      default: begin
        clock_oe_n = 1'b0;
        data_oe_n  = 1'b0;
        busy_n     = 1'b0;
        state_n    = IDLE;
      end
    endcase
  end

  assign bus.ps2_clock_oe     = clock_oe_q;
  assign bus.ps2_data_oe      = data_oe_q;
  assign bus.busy             = busy_q;
  assign bus.command_was_sent = sent_q;
  assign bus.error_timeout    = to_q;
  assign bus.error_no_ack     = nack_q;

endmodule

// File: tb/tb_ps2_command_tx.sv
module tb_ps2_command_tx;
  localparam int INH = 8;
  localparam int STO = 100;
  localparam int XTO = 500;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  ps2_command_tx_if bus();

  logic dev_clk = 1'b1;
  logic dev_data = 1'b1;
  logic line_clk, line_data;
  assign line_clk  = dev_clk & ~bus.ps2_clock_oe;
  assign line_data = dev_data & ~bus.ps2_data_oe;
  assign bus.ps2_clock_in = line_clk;
  assign bus.ps2_data_in  = line_data;

  ps2_command_tx #(
    .INHIBIT_CYCLES(INH),
    .START_TIMEOUT_CYCLES(STO),
    .XFER_TIMEOUT_CYCLES(XTO)
  ) dut (
    .inclock(clk),
    .resetn(resetn),
    .bus(bus)
  );

  int cyc = 0;
  int n_sent = 0;
  int n_to = 0;
  int n_nack = 0;
  int last_to_cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (bus.command_was_sent) n_sent <= n_sent + 1;
    if (bus.error_no_ack) n_nack <= n_nack + 1;
    if (bus.error_timeout) begin
      n_to <= n_to + 1;
      last_to_cyc <= cyc;
    end
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] cmd;
    logic       ack;
    int         n_edges;
    logic       inject;
    logic [9:0] exp_bits;
    int         exp_sent;
    int         exp_to;
    int         exp_nack;
  } vec_t;

  vec_t vecs[7];

  task automatic issue(input logic [7:0] c);
    @(negedge clk);
    bus.the_command  = c;
    bus.send_command = 1'b1;
    @(negedge clk);
    bus.send_command = 1'b0;
  endtask

  // counts clock-inhibit cycles; returns once the clock line is released
  task automatic inhibit_phase(output int n);
    n = 0;
    while (bus.ps2_clock_oe && n < 1000) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic run_xfer(input vec_t v);
    int s0, t0, k0, n, e1;
    logic [9:0] bits;
    s0 = n_sent; t0 = n_to; k0 = n_nack;
    bits = '0;
    issue(v.cmd);
    check("inhibit_data_oe", {31'd0, bus.ps2_data_oe}, 32'd0);
    check("busy_high", {31'd0, bus.busy}, 32'd1);
    inhibit_phase(n);
    check("inhibit_len", n, INH);
    check("start_bit", {31'd0, bus.ps2_data_oe}, 32'd1);
    if (v.inject) begin
      bus.the_command  = 8'hAA;
      bus.send_command = 1'b1;
      @(negedge clk);
      bus.send_command = 1'b0;
      check("busy_during_inject", {31'd0, bus.busy}, 32'd1);
    end
    repeat (10) @(negedge clk);
    e1 = cyc;
    for (int e = 1; e <= v.n_edges; e++) begin
      if (e == 11) begin
        dev_data = v.ack;
        repeat (5) @(negedge clk);
      end
      dev_clk = 1'b0;
      if (e == 1) e1 = cyc;
      repeat (20) @(negedge clk);
      if (e <= 10) bits[4'(e - 1)] = line_data;
      dev_clk = 1'b1;
      repeat (20) @(negedge clk);
    end
    dev_data = 1'b1;
    n = 0;
    while (bus.busy && n < 2000) begin
      n++;
      @(negedge clk);
    end
    check("busy_fall_bound", {31'd0, (n < 2000)}, 32'd1);
    repeat (5) @(negedge clk);
    check("frame_bits", {22'd0, bits}, {22'd0, v.exp_bits});
    check("sent_pulses", n_sent - s0, v.exp_sent);
    check("timeout_pulses", n_to - t0, v.exp_to);
    check("no_ack_pulses", n_nack - k0, v.exp_nack);
    check("lines_released", {30'd0, bus.ps2_clock_oe, bus.ps2_data_oe}, 32'd0);
    check("busy_low", {31'd0, bus.busy}, 32'd0);
    if (v.exp_to != 0)
      check("xfer_timeout_window",
            {31'd0, ((last_to_cyc - e1) >= 495) && ((last_to_cyc - e1) <= 510)}, 32'd1);
  endtask

  initial begin
    int n, t_rel, s0, t0, k0;
    vec_t vf4;
    bus.send_command = 1'b0;
    bus.the_command  = 8'h00;

    vecs[0] = '{8'hED, 1'b0, 11, 1'b0, 10'h3ED, 1, 0, 0};
    vecs[1] = '{8'h00, 1'b0, 11, 1'b0, 10'h300, 1, 0, 0};
    vecs[2] = '{8'hFF, 1'b0, 11, 1'b0, 10'h3FF, 1, 0, 0};
    vecs[3] = '{8'h01, 1'b0, 11, 1'b0, 10'h201, 1, 0, 0};
    vecs[4] = '{8'h3C, 1'b1, 11, 1'b0, 10'h33C, 0, 0, 1};
    vecs[5] = '{8'hA5, 1'b0, 5,  1'b0, 10'h005, 0, 1, 0};
    vecs[6] = '{8'h55, 1'b0, 11, 1'b1, 10'h355, 1, 0, 0};
    vf4     = '{8'hF4, 1'b0, 11, 1'b0, 10'h2F4, 1, 0, 0};

    // reset state
    repeat (3) @(negedge clk);
    check("reset_outputs",
          {26'd0, bus.ps2_clock_oe, bus.ps2_data_oe, bus.busy,
           bus.command_was_sent, bus.error_timeout, bus.error_no_ack}, 32'd0);
    resetn = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_after_reset",
          {29'd0, bus.ps2_clock_oe, bus.ps2_data_oe, bus.busy}, 32'd0);

    for (int i = 0; i < 7; i++) run_xfer(vecs[i]);

    // device silent after clock release
    s0 = n_sent; t0 = n_to;
    issue(8'h12);
    inhibit_phase(n);
    check("silent_inhibit_len", n, INH);
    t_rel = cyc;
    n = 0;
    while (!bus.error_timeout && n < 300) begin
      n++;
      @(negedge clk);
    end
    check("start_timeout_seen", {31'd0, (n < 300)}, 32'd1);
    check("start_timeout_window",
          {31'd0, ((cyc - t_rel) >= 98) && ((cyc - t_rel) <= 102)}, 32'd1);
    check("start_timeout_lines",
          {29'd0, bus.ps2_clock_oe, bus.ps2_data_oe, bus.busy}, 32'd0);
    repeat (20) @(negedge clk);
    check("start_timeout_once", n_to - t0, 1);
    check("start_timeout_no_sent", n_sent - s0, 0);

    // reset asserted during SEND
    s0 = n_sent; t0 = n_to; k0 = n_nack;
    issue(8'hA5);
    inhibit_phase(n);
    repeat (10) @(negedge clk);
    dev_clk = 1'b0;
    repeat (20) @(negedge clk);
    dev_clk = 1'b1;
    repeat (20) @(negedge clk);
    dev_clk = 1'b0;
    repeat (10) @(negedge clk);
    check("pre_reset_data_driven", {31'd0, bus.ps2_data_oe}, 32'd1);
    resetn = 1'b0;
    #1;
    check("reset_mid_lines",
          {29'd0, bus.ps2_clock_oe, bus.ps2_data_oe, bus.busy}, 32'd0);
    @(negedge clk);
    dev_clk = 1'b1;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (50) @(negedge clk);
    check("reset_mid_no_pulses", (n_sent - s0) + (n_to - t0) + (n_nack - k0), 0);
    run_xfer(vf4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: actual running required finished");
    $fatal(1, "simulation time limit");
  end
endmodule

// File: doc/ps2_command_tx.md
PS2_COMMAND_TX -- requirements
Module: ps2_command_tx

Interface
REQ-001 The block SHALL have parameter INHIBIT_CYCLES, default 5000, clock-low inhibit time in inclock cycles (100 us at 50 MHz).
REQ-002 The block SHALL have parameter START_TIMEOUT_CYCLES, default 750000, limit in cycles from clock release to the first device falling edge (15 ms).
REQ-003 The block SHALL have parameter XFER_TIMEOUT_CYCLES, default 100000, limit in cycles from the first device falling edge to ACK completion (2 ms).
REQ-004 inclock  input  1  system clock; all state updates on its rising edge.
REQ-005 resetn  input  1  asynchronous, active-low reset.
REQ-006 send_command  input  1  one-cycle request; accepted only when busy=0.
REQ-007 the_command  input  8  byte to transmit; sampled in the accept cycle.
REQ-008 ps2_clock_in  input  1  raw PS/2 clock line level, asynchronous.
REQ-009 ps2_data_in  input  1  raw PS/2 data line level, asynchronous.
REQ-010 ps2_clock_oe  output  1  1 = pull PS/2 clock low; 0 = release.
REQ-011 ps2_data_oe  output  1  1 = pull PS/2 data low; 0 = release.
REQ-012 busy  output  1  high from the accept cycle until return to IDLE.
REQ-013 command_was_sent  output  1  one-cycle pulse on successful ACK and bus idle.
REQ-014 error_timeout  output  1  one-cycle pulse when either timeout expires.
REQ-015 error_no_ack  output  1  one-cycle pulse when data is high at the ACK edge.

Function
REQ-016 ps2_clock_in and ps2_data_in SHALL each pass through a 2-flop synchronizer; a falling edge SHALL be detected as synchronized clock 1 then 0 on consecutive cycles.
REQ-017 All outputs SHALL be registered.
REQ-018 The FSM SHALL have states IDLE, INHIBIT, REQ_START, SEND, WAIT_IDLE.
REQ-019 IDLE: both oe=0 and busy=0; send_command=1 SHALL latch the_command plus odd parity (XOR of byte inverted), clear the counters and enter INHIBIT.
REQ-020 INHIBIT: ps2_clock_oe=1 and ps2_data_oe=0 for exactly INHIBIT_CYCLES cycles, then ps2_data_oe=1 (start bit) and the FSM SHALL enter REQ_START.
REQ-021 REQ_START: ps2_clock_oe=0 and ps2_data_oe=1; the first device falling edge SHALL drive bit0 and enter SEND with bit index 1.
REQ-022 If no falling edge occurs within START_TIMEOUT_CYCLES in REQ_START, the block SHALL pulse error_timeout and return to IDLE.
REQ-023 SEND: falling edges 2-8 SHALL drive data bits d1-d7 (LSB first), edge 9 parity, edge 10 stop (release).
REQ-024 The data line SHALL be driven as ps2_data_oe = NOT(bit value), changing in the cycle after edge detection.
REQ-025 At edge 11 the block SHALL sample synchronized data: 0 -> WAIT_IDLE; 1 -> pulse error_no_ack and return to IDLE.
REQ-026 WAIT_IDLE: once synchronized clock and data are both 1, the block SHALL pulse command_was_sent and return to IDLE.
REQ-027 The transfer counter SHALL run from the first falling edge through WAIT_IDLE; reaching XFER_TIMEOUT_CYCLES SHALL pulse error_timeout, release both lines and return to IDLE.
REQ-028 send_command while busy=1 SHALL be ignored, with no effect on the latched byte.
REQ-029 Counters SHALL saturate; each timeout pulse SHALL fire at most once per transfer.
REQ-030 Exactly one of command_was_sent, error_timeout and error_no_ack SHALL pulse per accepted command.

Reset
REQ-031 resetn=0 SHALL immediately force IDLE, all outputs 0, counters, bit index, shift register and synchronizers to 0 (synchronizers to 1).
REQ-032 Reset asserted mid-transfer SHALL release both lines without any completion or error pulse.

Verification
REQ-033 INHIBIT_CYCLES=8; send 0xED; model device clocking at 40-cycle period with ACK low at edge 11 -> clock_oe high for 8 cycles; data sequence 0,1,0,1,1,0,1,1,1,parity 1,stop 1; command_was_sent pulses once; busy falls.
REQ-034 START_TIMEOUT_CYCLES=100 with the device silent -> error_timeout pulses once ~100 cycles after clock release; both oe=0; busy=0.
REQ-035 Device ACK bit high at edge 11 -> error_no_ack pulses once; command_was_sent stays 0.
REQ-036 Device stops clocking after edge 5 with XFER_TIMEOUT_CYCLES=500 -> error_timeout at cycle 500 after edge 1; lines released.
REQ-037 send_command 0x55 then 0xAA while busy -> only 0x55 (parity 1) is transmitted.
REQ-038 resetn pulsed low during SEND -> both oe=0 immediately; no pulse outputs; next 0xF4 transfers correctly.
